// File: rtl/x2c_pkg.sv
// ---------------------------------------------------------------------------
// x2c_pkg : shared arbiter state encoding and control-lane width
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package x2c_pkg;

  localparam int unsigned X2C_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } x2c_state_e;

endpackage

`default_nettype wire

// File: rtl/x2c_rr_pick.sv
// ---------------------------------------------------------------------------
// x2c_rr_pick : combinational round-robin picker, search starts at last+1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module x2c_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_gnt,
  output logic [IDXW-1:0] gnt,
  output logic            any
);

  logic            found;
  logic [IDXW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDXW'((32'(last_gnt) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/x2c_ctrl_arb.sv
// ---------------------------------------------------------------------------
// x2c_ctrl_arb : round-robin descriptor arbiter feeding an external control FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module x2c_ctrl_arb
  import x2c_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = X2C_WIDTH,
  parameter int unsigned MAXLEN = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_wrreq,
  output logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_full,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic                     err_len,
  input  logic                     err_clr
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned CNTW = $clog2(MAXLEN) + 1;

  x2c_state_e      state_q, state_d;
  logic [IDXW-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] last_gnt_q, last_gnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            active;
  logic            wr;
  logic            at_max;
  logic            term;

  x2c_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .gnt      (pick_idx),
    .any      (pick_any)
  );

  // Reset gates the datapath combinationally so nothing leaks out in the reset cycle.
  always_comb begin
    active     = (state_q == ST_XFER) && !reset;
    wr         = active && req_valid[gnt_q] && !fifo_full;
    at_max     = (cnt_q == CNTW'(MAXLEN - 1));
    term       = wr && (req_last[gnt_q] || at_max);

    req_ready  = '0;
    if (active) req_ready[gnt_q] = ~fifo_full;
    fifo_wrreq = wr;
    fifo_data  = active ? req_data[gnt_q*WIDTH +: WIDTH] : '0;
    gnt_id     = reset ? '0 : gnt_q;
    busy       = active;
    err_len    = err_q && !reset;

    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_XFER;
          gnt_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        if (wr) cnt_d = cnt_q + 1'b1;
        if (term) begin
          state_d    = ST_IDLE;
          last_gnt_d = gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A length overrun outranks a simultaneous clear.
    err_d = err_q;
    if (wr && !req_last[gnt_q] && at_max) err_d = 1'b1;
    else if (err_clr)                     err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= IDXW'(NREQ - 1);
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_x2c_ctrl_arb.sv
// ---------------------------------------------------------------------------
// tb_x2c_ctrl_arb : scoreboard bench for the x2c control arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_x2c_ctrl_arb;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 32;
  localparam int MAXLEN = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wrreq;
  logic [WIDTH-1:0]      fifo_data;
  logic                  fifo_full = 1'b0;
  logic [1:0]            gnt_id;
  logic                  busy;
  logic                  err_len;
  logic                  err_clr = 1'b0;

  always #5 clk = ~clk;

  x2c_ctrl_arb #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .MAXLEN (MAXLEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .err_len    (err_len),
    .err_clr    (err_clr)
  );

  typedef struct packed {logic [WIDTH-1:0] d; logic l;} word_t;
  typedef struct packed {logic [1:0] id; logic [WIDTH-1:0] d; logic term;} exp_t;

  word_t           lq[NREQ][$];
  exp_t            sb[$];
  exp_t            e_m;
  logic [NREQ-1:0] en = '1;
  logic [NREQ-1:0] acc = '0;
  logic            prev_term = 1'b0;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (lq[i].size() > 0) begin
        req_valid[i]                = en[i];
        req_data[i*WIDTH +: WIDTH]  = lq[i][0].d;
        req_last[i]                 = lq[i][0].l;
      end else begin
        req_valid[i]                = 1'b0;
        req_data[i*WIDTH +: WIDTH]  = '0;
        req_last[i]                 = 1'b0;
      end
    end
  endtask

  // One descriptor of n words on a lane; expected writes queued in issue order.
  task automatic desc(input int lane, input logic [WIDTH-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      lq[lane].push_back('{d: base + WIDTH'(k), l: (k == n - 1)});
      sb.push_back('{id: 2'(lane), d: base + WIDTH'(k), term: (k == n - 1)});
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) lq[i].delete();
    sb.delete();
  endtask

  task automatic wait_size(input string name, input int n);
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      if (sb.size() == n) begin ok = 1'b1; break; end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_wrreq"}, 64'(fifo_wrreq), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_gnt"},   64'(gnt_id), 64'd0);
    chk({tag, "_err"},   64'(err_len), 64'd0);
    chk({tag, "_data"},  64'(fifo_data), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    flush();
    drive();
    @(negedge clk);
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every FIFO write; a terminating word
  // must be followed by at least one write-free cycle.
  always @(negedge clk) begin
    acc = req_ready & req_valid;
    if (fifo_wrreq) begin
      chk("idle_gap", 64'(prev_term), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(sb.size()), 64'd1);
        prev_term = 1'b0;
      end else begin
        e_m = sb.pop_front();
        chk("wr_data", 64'(fifo_data), 64'(e_m.d));
        chk("wr_id", 64'(gnt_id), 64'(e_m.id));
        prev_term = e_m.term;
      end
    end else begin
      prev_term = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) void'(lq[i].pop_front());
    drive();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single 3-word descriptor on lane 0.
    desc(0, 32'h0000_00A0, 3);
    drive();
    @(negedge clk); chk("s1_busy_c0", 64'(busy), 64'd0);
    @(negedge clk); chk("s1_busy_c1", 64'(busy), 64'd1);
                    chk("s1_gnt_c1", 64'(gnt_id), 64'd0);
    @(negedge clk);
    @(negedge clk); chk("s1_busy_c3", 64'(busy), 64'd1);
    @(negedge clk); chk("s1_busy_c4", 64'(busy), 64'd0);
    wait_drain("s1_drain");

    // All lanes competing: expected grant order 0,1,2,3,0.
    do_reset();
    desc(0, 32'h0000_0B00, 2);
    desc(1, 32'h0000_0B10, 2);
    desc(2, 32'h0000_0B20, 2);
    desc(3, 32'h0000_0B30, 2);
    desc(0, 32'h0000_0B40, 2);
    drive();
    wait_drain("s2_drain");

    // FIFO full for 5 cycles after word 2 of a 4-word descriptor.
    desc(3, 32'h0000_0C00, 4);
    drive();
    wait_size("s3_word2", 2);
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("s3_ready_stall", 64'(req_ready), 64'd0);
      chk("s3_wr_stall", 64'(fifo_wrreq), 64'd0);
      chk("s3_gnt_stall", 64'(gnt_id), 64'd3);
      chk("s3_busy_stall", 64'(busy), 64'd1);
    end
    @(posedge clk); #2 fifo_full = 1'b0;
    wait_drain("s3_drain");
    chk("s3_err", 64'(err_len), 64'd0);

    // 16 words with no last: word 16 terminates, word 17 opens a new descriptor.
    for (int k = 0; k < 18; k++) begin
      lq[2].push_back('{d: 32'h0000_0D00 + 32'(k), l: (k == 17)});
      sb.push_back('{id: 2'd2, d: 32'h0000_0D00 + 32'(k), term: (k == 15 || k == 17)});
    end
    drive();
    wait_drain("s4_drain");
    chk("s4_err_set", 64'(err_len), 64'd1);
    @(posedge clk); #2 err_clr = 1'b1;
    @(posedge clk); #2 err_clr = 1'b0;
    @(negedge clk); chk("s4_err_clr", 64'(err_len), 64'd0);

    // Reset after word 2 of a 5-word descriptor on lane 1.
    desc(1, 32'h0000_0E00, 5);
    drive();
    wait_size("s5_word2", 3);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("s5_rst");
    @(posedge clk); #2;
    reset = 1'b0;
    flush();
    desc(0, 32'h0000_0F00, 2);
    desc(1, 32'h0000_0F10, 2);
    drive();
    wait_drain("s5_drain");

    // Granted lane 0 bubbles 3 cycles while lane 1 waits.
    desc(0, 32'h0000_0100, 4);
    desc(1, 32'h0000_0110, 2);
    drive();
    wait_size("s6_word2", 4);
    en[0] = 1'b0;
    drive();
    repeat (3) begin
      @(negedge clk);
      chk("s6_wr_gap", 64'(fifo_wrreq), 64'd0);
      chk("s6_gnt_gap", 64'(gnt_id), 64'd0);
      chk("s6_busy_gap", 64'(busy), 64'd1);
    end
    @(posedge clk); #2;
    en[0] = 1'b1;
    drive();
    wait_drain("s6_drain");

    chk("end_lanes_empty", 64'(lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/x2c_ctrl_arb.md
X2C_CTRL_ARB -- requirements
Module: x2c_ctrl_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 32, control-word width, equal to the control FIFO WIDTH.
REQ-003 Parameter MAXLEN, default 16, maximum words per descriptor.
REQ-004 Port clk  in  1  single clock for all logic.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port req_valid  in  NREQ  requester i has a word on its data lane.
REQ-007 Port req_data  in  NREQ*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port req_last  in  NREQ  the word on lane i is the final word of its descriptor.
REQ-009 Port req_ready  out  NREQ  the word on lane i is accepted this cycle.
REQ-010 Port fifo_wrreq  out  1  write request to the control FIFO write port.
REQ-011 Port fifo_data  out  WIDTH  write data to the control FIFO.
REQ-012 Port fifo_full  in  1  control FIFO full flag.
REQ-013 Port gnt_id  out  clog2(NREQ)  index of the current grant holder.
REQ-014 Port busy  out  1  a descriptor transfer is in progress.
REQ-015 Port err_len  out  1  sticky flag: a descriptor exceeded MAXLEN.
REQ-016 Port err_clr  in  1  clears err_len.

Function
REQ-017 The arbiter SHALL be a two-state FSM: IDLE and XFER.
REQ-018 IDLE arbitration:
  - When any req_valid bit is set, grant the first set bit in round-robin order, starting at last_gnt+1 modulo NREQ.
  - Register the result in gnt_id and move to XFER on the next edge.
  - Stay in IDLE while req_valid is all zero.
REQ-019 In XFER, req_ready[gnt_id] SHALL equal ~fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-020 In XFER, fifo_wrreq SHALL equal req_valid[gnt_id] & ~fifo_full and fifo_data SHALL equal lane gnt_id, with zero added latency.
REQ-021 In IDLE, fifo_wrreq and req_ready SHALL be 0 and fifo_data SHALL be 0.
REQ-022 A word is accepted when fifo_wrreq is 1; the word counter SHALL increment on each accepted word.
REQ-023 The word counter is clog2(MAXLEN)+1 bits wide and SHALL clear on entry to XFER.
REQ-024 Descriptors SHALL be atomic: the grant SHALL be held until an accepted word has req_last set, irrespective of other requesters.
REQ-025 When a word with req_last set is accepted, the FSM SHALL return to IDLE, last_gnt SHALL be loaded with gnt_id, and the next grant SHALL occur no earlier than 1 cycle later.
REQ-026 When the MAXLEN-th word is accepted with req_last clear:
  - set err_len;
  - treat that word as terminating (return to IDLE, update last_gnt);
  - subsequent words from that requester form a new descriptor.
REQ-027 fifo_full asserted mid-descriptor SHALL stall the transfer with no word lost, no word duplicated and no loss of grant.
REQ-028 A granted requester dropping req_valid mid-descriptor SHALL be treated as a bubble; the grant is kept.
REQ-029 err_clr and a new error in the same cycle: err_len SHALL remain 1 (set wins).
REQ-030 busy SHALL be 1 exactly while the FSM is in XFER.

Reset
REQ-031 On reset, while reset is high:
  - state = IDLE;
  - last_gnt = NREQ-1, so requester 0 has first priority;
  - gnt_id = 0, word counter = 0, err_len = 0, busy = 0;
  - all req_ready = 0, fifo_wrreq = 0.
REQ-032 Reset asserted mid-descriptor SHALL abort it immediately; no write occurs in the reset cycle, and no partial-descriptor state survives.

Structure
REQ-033 The state encoding (IDLE, XFER) and the lane-slicing constant WIDTH SHALL reside in the shared x2c package.
REQ-034 The round-robin priority picker SHALL be one sub-module, x2c_rr_pick:
  - inputs: request vector, last grant;
  - outputs: grant index, any-valid;
  - purely combinational.
REQ-035 The FIFO instance SHALL stay outside this block.

Verification
REQ-036 Scenario: reset, then req_valid=4'b0001 with a 3-word descriptor 0xA0..0xA2, last on 0xA2 -> gnt_id=0, 3 writes on consecutive cycles, busy falls the cycle after 0xA2.
REQ-037 Scenario: all 4 requesters valid with 2-word descriptors -> grant order 0,1,2,3,0, one IDLE cycle between descriptors, no interleaving.
REQ-038 Scenario: fifo_full held high for 5 cycles after the 2nd word of a 4-word descriptor -> exactly 4 FIFO writes in order, grant kept, req_ready low for those 5 cycles.
REQ-039 Scenario: MAXLEN=16, requester 2 sends 17 words with no last -> err_len=1 after word 16, requester 2 is re-arbitrated, word 17 starts a new descriptor; err_clr pulse -> err_len=0.
REQ-040 Scenario: reset pulsed after word 2 of 5 -> no FIFO write in the reset cycle, all outputs at reset values, next grant goes to requester 0.
REQ-041 Scenario: granted requester deasserts req_valid for 3 cycles mid-descriptor while requester 1 is valid -> no write during the gap, grant unchanged, the descriptor completes, then requester 1 is granted.
